// File: rtl/jackpot_round_ctrl.sv
// Jackpot board game sequencer: one-hot LED rotation, synchronised switch
// edge detection, hit/miss judging, levels with a shrinking step period.
module jackpot_round_ctrl #(
  parameter int unsigned TICK_DIV   = 7000000,
  parameter int unsigned LEVEL_STEP = 1000000,
  parameter int unsigned NUM_LEVELS = 4,
  parameter int unsigned WIN_HOLD   = 8,
  parameter int unsigned MAX_MISSES = 3
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       START,
  input  logic [3:0] SWITCHES,
  output logic [3:0] LEDS,
  output logic [1:0] LEVEL,
  output logic [7:0] SCORE,
  output logic [2:0] MISSES,
  output logic       GAME_OVER
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW = $clog2(WIN_HOLD + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WIN,
    S_OVER,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      sync1_q, sync1_d;
  logic [3:0]      sync2_q, sync2_d;
  logic [3:0]      prev_q, prev_d;
  logic [CW-1:0]   timer_q, timer_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [3:0]      leds_q, leds_d;
  logic [1:0]      level_q, level_d;
  logic [7:0]      score_q, score_d;
  logic [2:0]      misses_q, misses_d;
  logic            game_over_q, game_over_d;

  logic [3:0]      rise;
  logic [31:0]     period_m1;
  logic            step_tick;
  logic            hit;
  logic            miss;
  logic            new_game;

  // The game-over toggle always runs at the level-0 rate.
  always_comb begin
    if (state_q == S_OVER) period_m1 = TICK_DIV - 1;
    else                   period_m1 = TICK_DIV - 32'(level_q) * LEVEL_STEP - 1;
  end

  assign rise      = sync2_q & ~prev_q;
  assign step_tick = (32'(timer_q) == period_m1);
  assign hit       = $onehot(rise) && (rise == leds_q);
  assign miss      = (rise != '0) && !hit;
  assign new_game  = START && (state_q == S_IDLE || state_q == S_OVER ||
                               state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    sync1_d     = SWITCHES;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    timer_d     = step_tick ? '0 : timer_q + CW'(1);
    hold_d      = hold_q;
    leds_d      = leds_q;
    level_d     = level_q;
    score_d     = score_q;
    misses_d    = misses_q;
    game_over_d = game_over_q;

    if (new_game) begin
      state_d     = S_RUN;
      leds_d      = 4'b0001;
      level_d     = '0;
      score_d     = '0;
      misses_d    = '0;
      timer_d     = '0;
      game_over_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          timer_d = '0;
          leds_d  = '0;
        end
        S_RUN: begin
          // A decision takes priority over a coincident rotation step.
          if (hit) begin
            score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            state_d = S_WIN;
            leds_d  = '1;
            timer_d = '0;
            hold_d  = '0;
          end else if (miss) begin
            misses_d = misses_q + 3'd1;
            if (misses_d == 3'(MAX_MISSES)) begin
              state_d     = S_OVER;
              leds_d      = 4'b0101;
              timer_d     = '0;
              game_over_d = 1'b1;
            end
          end else if (step_tick) begin
            leds_d = {leds_q[2:0], leds_q[3]};
          end
        end
        S_WIN: begin
          if (step_tick) begin
            if (hold_q == HW'(WIN_HOLD - 1)) begin
              timer_d = '0;
              if (level_q == 2'(NUM_LEVELS - 1)) begin
                state_d     = S_DONE;
                game_over_d = 1'b1;
              end else begin
                state_d = S_RUN;
                level_d = level_q + 2'd1;
                leds_d  = 4'b0001;
              end
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
        end
        S_OVER: begin
          if (step_tick) leds_d = ~leds_q;
        end
        S_DONE: begin
          timer_d = '0;
        end
        default: begin
          state_d = S_IDLE;
          leds_d  = '0;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      timer_q     <= '0;
      hold_q      <= '0;
      leds_q      <= '0;
      level_q     <= '0;
      score_q     <= '0;
      misses_q    <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      timer_q     <= timer_d;
      hold_q      <= hold_d;
      leds_q      <= leds_d;
      level_q     <= level_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      game_over_q <= game_over_d;
    end
  end

  assign LEDS      = leds_q;
  assign LEVEL     = level_q;
  assign SCORE     = score_q;
  assign MISSES    = misses_q;
  assign GAME_OVER = game_over_q;

endmodule

// File: tb/tb_jackpot_round_ctrl.sv
// Directed plus random bench for jackpot_round_ctrl against a behavioural
// game model driven from the switch sample history.
module tb_jackpot_round_ctrl;

  localparam int TD = 10;
  localparam int LS = 2;
  localparam int NL = 2;
  localparam int WH = 2;
  localparam int MM = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] sw = 4'b0000;
  logic [3:0] leds;
  logic [1:0] level;
  logic [7:0] score;
  logic [2:0] misses;
  logic       game_over;
  logic [17:0] dut_vec;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  jackpot_round_ctrl #(
    .TICK_DIV  (TD),
    .LEVEL_STEP(LS),
    .NUM_LEVELS(NL),
    .WIN_HOLD  (WH),
    .MAX_MISSES(MM)
  ) dut (
    .CLOCK    (clk),
    .RESET    (rst),
    .START    (start),
    .SWITCHES (sw),
    .LEDS     (leds),
    .LEVEL    (level),
    .SCORE    (score),
    .MISSES   (misses),
    .GAME_OVER(game_over)
  );

  assign dut_vec = {leds, level, score, misses, game_over};

  // Behavioural model of the game
  typedef enum {MD_IDLE, MD_RUN, MD_WIN, MD_OVER, MD_DONE} mode_t;
  mode_t      md;
  int         pos, lvl, m_score, m_misses, timer, holds;
  bit         alt;
  logic [3:0] hist [4];

  function automatic void m_reset();
    md = MD_IDLE; pos = 0; lvl = 0; m_score = 0; m_misses = 0;
    timer = 0; holds = 0; alt = 1'b0;
    for (int i = 0; i < 4; i++) hist[i] = 4'b0000;
  endfunction

  function automatic void m_new_game();
    md = MD_RUN; pos = 0; lvl = 0; m_score = 0; m_misses = 0; timer = 0;
  endfunction

  function automatic void m_step(input logic [3:0] s, input bit st);
    logic [3:0] r;
    int         period;
    bit         tk;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
    r = hist[2] & ~hist[3];
    period = (md == MD_OVER) ? TD : TD - lvl * LS;
    tk = (timer == period - 1);
    timer = tk ? 0 : timer + 1;
    case (md)
      MD_IDLE: begin
        timer = 0;
        if (st) m_new_game();
      end
      MD_RUN: begin
        if (r != 4'b0000) begin
          if ($countones(r) == 1 && r == 4'(1 << pos)) begin
            m_score = (m_score < 255) ? m_score + 1 : 255;
            md = MD_WIN; holds = 0; timer = 0;
          end else begin
            m_misses++;
            if (m_misses == MM) begin
              md = MD_OVER; alt = 1'b0; timer = 0;
            end
          end
        end else if (tk) begin
          pos = (pos + 1) % 4;
        end
      end
      MD_WIN: begin
        if (tk) begin
          holds++;
          if (holds == WH) begin
            timer = 0;
            if (lvl == NL - 1) md = MD_DONE;
            else begin
              lvl++; md = MD_RUN; pos = 0;
            end
          end
        end
      end
      MD_OVER: begin
        if (st) m_new_game();
        else if (tk) alt = ~alt;
      end
      default: begin
        timer = 0;
        if (st) m_new_game();
      end
    endcase
  endfunction

  function automatic logic [17:0] m_out();
    logic [3:0] l;
    case (md)
      MD_IDLE:        l = 4'h0;
      MD_RUN:         l = 4'(1 << pos);
      MD_WIN, MD_DONE: l = 4'hF;
      default:        l = alt ? 4'hA : 4'h5;
    endcase
    return {l, 2'(lvl), 8'(m_score), 3'(m_misses), (md == MD_OVER || md == MD_DONE)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst) m_reset();
      else     m_step(sw, start);
      #1;
      chk("cycle", 32'(dut_vec), 32'(m_out()));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  logic [3:0] exp_rot [4];
  int         r;

  initial begin
    exp_rot[0] = 4'b0010; exp_rot[1] = 4'b0100;
    exp_rot[2] = 4'b1000; exp_rot[3] = 4'b0001;
    m_reset();

    // Reset and start
    tick(3);
    chk("reset_outputs", 32'(dut_vec), 32'h0);
    rst = 1'b0;
    tick(2);
    chk("idle_leds", 32'(leds), 32'h0);
    pulse_start();
    chk("start_led", 32'(leds), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick(10);
      chk("rotate", 32'(leds), 32'(exp_rot[i]));
    end

    // Hit at level 0, then level-up
    tick(20);
    chk("led_0100", 32'(leds), 32'h4);
    sw = 4'b0100;
    tick(2);
    chk("hit_not_yet", 32'(leds), 32'h4);
    tick(1);
    chk("hit_leds", 32'(leds), 32'hF);
    chk("hit_score", 32'(score), 32'h1);
    tick(19);
    chk("win_hold", 32'({leds, level}), 32'({4'hF, 2'd0}));
    tick(1);
    chk("level_up", 32'({leds, level}), 32'({4'h1, 2'd1}));

    // Misses up to the limit
    sw = 4'b0010;
    tick(3);
    chk("miss1", 32'({leds, misses}), 32'({4'h1, 3'd1}));
    tick(5);
    chk("rot_l1", 32'(leds), 32'h2);
    sw = 4'b1011;
    tick(3);
    chk("over_enter", 32'({leds, misses, game_over}), 32'({4'h5, 3'd2, 1'b1}));
    tick(10);
    chk("over_a", 32'(leds), 32'hA);
    tick(10);
    chk("over_5", 32'(leds), 32'h5);

    // Hit decided on the step_tick cycle
    sw = 4'b0000;
    tick(4);
    pulse_start();
    chk("restart", 32'({leds, level, score, misses, game_over}), 32'({4'h1, 2'd0, 8'd0, 3'd0, 1'b0}));
    tick(7);
    sw = 4'b0001;
    tick(3);
    chk("hit_on_tick", 32'({leds, score}), 32'({4'hF, 8'd1}));

    // Full clear to DONE
    tick(20);
    chk("level_up2", 32'({leds, level}), 32'({4'h1, 2'd1}));
    sw = 4'b0000;
    tick(1);
    sw = 4'b0001;
    tick(3);
    chk("hit_l1", 32'({leds, score}), 32'({4'hF, 8'd2}));
    tick(16);
    chk("done", 32'({leds, level, score, game_over}), 32'({4'hF, 2'd1, 8'd2, 1'b1}));
    tick(5);
    chk("done_held", 32'({leds, level, score, game_over}), 32'({4'hF, 2'd1, 8'd2, 1'b1}));
    pulse_start();
    chk("done_restart", 32'({leds, level, score, misses, game_over}), 32'({4'h1, 2'd0, 8'd0, 3'd0, 1'b0}));

    // Reset mid-WIN with switches held high
    sw = 4'b0000;
    tick(1);
    sw = 4'b0001;
    tick(3);
    chk("win_again", 32'(leds), 32'hF);
    sw = 4'hF;
    tick(2);
    rst = 1'b1;
    #1;
    m_reset();
    chk("async_reset", 32'(dut_vec), 32'h0);
    tick(3);
    rst = 1'b0;
    tick(5);
    pulse_start();
    tick(30);
    chk("held_no_rise", 32'({score, misses}), 32'h0);
    sw = 4'b1101;
    tick(2);
    sw = 4'hF;
    tick(3);
    chk("relower_rise", 32'(score) + 32'(misses), 32'd1);

    // Random play
    for (int c = 0; c < 4000; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3)      sw[$urandom_range(0, 3)] ^= 1'b1;
      else if (r < 6) sw[pos] ^= 1'b1;
      start = ($urandom_range(0, 149) == 0);
      rst   = ($urandom_range(0, 1499) == 0);
      tick(1);
    end
    start = 1'b0;
    rst = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
